// File: rtl/uart_rx_pkg.sv
// Shared UART receive-path definitions.
// Holds the frame-length limits and the helper that clamps a requested
// data-bit count into the legal range of the receiver.
package uart_rx_pkg;

  localparam int unsigned UART_MIN_DATA_BITS    = 32'd5;
  localparam int unsigned UART_DEFAULT_PRESCALE = 32'd8;

  // Clamp a requested data-bit count to [UART_MIN_DATA_BITS, max_len].
  function automatic int unsigned clamp_frame_len(input int unsigned req_len,
                                                  input int unsigned max_len);
    int unsigned len_v;
    if (req_len < UART_MIN_DATA_BITS) begin
      len_v = UART_MIN_DATA_BITS;
    end else if (req_len > max_len) begin
      len_v = max_len;
    end else begin
      len_v = req_len;
    end
    return len_v;
  endfunction

endpackage

// File: rtl/deser_bit_counter.sv
// Bit-position tracker for a UART data phase.
// Detects the capture strobe, counts captured bits, latches frame length and
// bit order on the first capture of a frame and flags completion/abort.
// Ports:
//   clk, rst           clock, async active-low reset
//   des_en             data-bit phase active
//   edge_cnt, prescale oversampling position and ratio
//   frame_len          requested data bits (clamped on latch)
//   lsb_first          requested bit order
//   cap                capture strobe this cycle (combinational)
//   done               this capture completes the frame (combinational)
//   abort              des_en dropped mid-frame (combinational)
//   bit_cnt            bits captured so far in the current frame
//   len_sel, order_sel length/order governing the current capture
//   busy               registered (bit_cnt != 0)
module deser_bit_counter
  import uart_rx_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int PRESC_W    = 6,
  localparam int CNT_W     = $clog2(DATA_WIDTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               des_en,
  input  logic [PRESC_W-1:0] edge_cnt,
  input  logic [PRESC_W-1:0] prescale,
  input  logic [CNT_W-1:0]   frame_len,
  input  logic               lsb_first,
  output logic               cap,
  output logic               done,
  output logic               abort,
  output logic [CNT_W-1:0]   bit_cnt,
  output logic [CNT_W-1:0]   len_sel,
  output logic               order_sel,
  output logic               busy
);

  logic [CNT_W-1:0]   bit_cnt_r;
  logic [CNT_W-1:0]   bit_cnt_nxt_s;
  logic [CNT_W-1:0]   len_q_r;
  logic               order_q_r;
  logic               busy_r;
  logic [PRESC_W-1:0] last_edge_s;
  logic               cap_s;
  logic               first_s;
  logic [CNT_W-1:0]   req_len_s;
  logic [CNT_W-1:0]   len_sel_s;
  logic               order_sel_s;
  logic               done_s;
  logic               abort_s;

  // Strobe detection, frame parameter selection and next bit count.
  always_comb begin
    last_edge_s   = prescale - PRESC_W'(1);
    cap_s         = 1'b0;
    bit_cnt_nxt_s = bit_cnt_r;
    // prescale of 0 or 1 would wrap or match every cycle, so it never strobes.
    if (des_en && (prescale > PRESC_W'(1)) && (edge_cnt == last_edge_s)) begin
      cap_s = 1'b1;
    end else begin
      cap_s = 1'b0;
    end
    first_s   = cap_s && (bit_cnt_r == {CNT_W{1'b0}});
    req_len_s = CNT_W'(clamp_frame_len(32'(frame_len), 32'(DATA_WIDTH)));
    // The first capture already uses the freshly latched values.
    if (first_s) begin
      len_sel_s   = req_len_s;
      order_sel_s = lsb_first;
    end else begin
      len_sel_s   = len_q_r;
      order_sel_s = order_q_r;
    end
    done_s  = cap_s && (bit_cnt_r == (len_sel_s - CNT_W'(1)));
    abort_s = !des_en && (bit_cnt_r != {CNT_W{1'b0}});
    if (abort_s || done_s) begin
      bit_cnt_nxt_s = {CNT_W{1'b0}};
    end else if (cap_s) begin
      bit_cnt_nxt_s = bit_cnt_r + CNT_W'(1);
    end else begin
      bit_cnt_nxt_s = bit_cnt_r;
    end
  end

  // Bit counter, per-frame length/order latch and busy flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_cnt_r <= {CNT_W{1'b0}};
      len_q_r   <= {CNT_W{1'b0}};
      order_q_r <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      bit_cnt_r <= bit_cnt_nxt_s;
      if (first_s) begin
        len_q_r   <= req_len_s;
        order_q_r <= lsb_first;
      end
      busy_r <= (bit_cnt_nxt_s != {CNT_W{1'b0}});
    end
  end

  assign cap       = cap_s;
  assign done      = done_s;
  assign abort     = abort_s;
  assign bit_cnt   = bit_cnt_r;
  assign len_sel   = len_sel_s;
  assign order_sel = order_sel_s;
  assign busy      = busy_r;

endmodule

// File: rtl/deser_shift_unit.sv
// UART receive deserializer: collects one sampled bit per bit period into a
// right-justified word with runtime prescale, frame length and bit order.
// Ports:
//   clk, rst       clock, async active-low reset
//   des_en         data-bit phase active
//   sampled_bit    voted bit from the data sampler
//   edge_cnt       oversampling edge counter
//   prescale       oversampling ratio (quasi-static)
//   frame_len      data bits per frame (clamped to 5..DATA_WIDTH)
//   lsb_first      1 = LSB first, 0 = MSB first
//   p_data         last completed word, upper bits zero
//   data_valid     one-cycle pulse when p_data updates
//   busy           a frame is partially collected
//   frame_abort    one-cycle pulse when des_en drops mid-frame
module deser_shift_unit
  import uart_rx_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int PRESC_W    = 6,
  localparam int CNT_W     = $clog2(DATA_WIDTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  des_en,
  input  logic                  sampled_bit,
  input  logic [PRESC_W-1:0]    edge_cnt,
  input  logic [PRESC_W-1:0]    prescale,
  input  logic [CNT_W-1:0]      frame_len,
  input  logic                  lsb_first,
  output logic [DATA_WIDTH-1:0] p_data,
  output logic                  data_valid,
  output logic                  busy,
  output logic                  frame_abort
);

  logic                  cap_s;
  logic                  done_s;
  logic                  abort_s;
  logic [CNT_W-1:0]      bit_cnt_s;
  logic [CNT_W-1:0]      len_sel_s;
  logic                  order_sel_s;
  logic [DATA_WIDTH-1:0] shift_r;
  logic [DATA_WIDTH-1:0] shift_cap_s;
  logic [DATA_WIDTH-1:0] shift_nxt_s;
  logic [DATA_WIDTH-1:0] bit_sel_s;
  logic [DATA_WIDTH-1:0] len_mask_s;
  logic [DATA_WIDTH-1:0] p_data_r;
  logic                  data_valid_r;
  logic                  frame_abort_r;

  deser_bit_counter #(
    .DATA_WIDTH (DATA_WIDTH),
    .PRESC_W    (PRESC_W)
  ) u_bit_counter (
    .clk       (clk),
    .rst       (rst),
    .des_en    (des_en),
    .edge_cnt  (edge_cnt),
    .prescale  (prescale),
    .frame_len (frame_len),
    .lsb_first (lsb_first),
    .cap       (cap_s),
    .done      (done_s),
    .abort     (abort_s),
    .bit_cnt   (bit_cnt_s),
    .len_sel   (len_sel_s),
    .order_sel (order_sel_s),
    .busy      (busy)
  );

  // Insert the sampled bit and compute the next shift register contents.
  always_comb begin
    // One-hot select avoids indexing with a counter wider than the word.
    bit_sel_s  = {{(DATA_WIDTH-1){1'b0}}, 1'b1} << bit_cnt_s;
    // Shifting all-ones by len_sel leaves ones only at valid positions after inversion.
    len_mask_s = ~({DATA_WIDTH{1'b1}} << len_sel_s);
    if (order_sel_s) begin
      if (sampled_bit) begin
        shift_cap_s = shift_r | bit_sel_s;
      end else begin
        shift_cap_s = shift_r & ~bit_sel_s;
      end
    end else begin
      shift_cap_s = {shift_r[DATA_WIDTH-2:0], sampled_bit};
    end
    if (abort_s || done_s) begin
      shift_nxt_s = {DATA_WIDTH{1'b0}};
    end else if (cap_s) begin
      shift_nxt_s = shift_cap_s;
    end else begin
      shift_nxt_s = shift_r;
    end
  end

  // Shift register, output word and event pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shift_r       <= {DATA_WIDTH{1'b0}};
      p_data_r      <= {DATA_WIDTH{1'b0}};
      data_valid_r  <= 1'b0;
      frame_abort_r <= 1'b0;
    end else begin
      shift_r <= shift_nxt_s;
      if (done_s) begin
        p_data_r <= shift_cap_s & len_mask_s;
      end
      // done needs des_en high and abort needs it low, so these never coincide.
      data_valid_r  <= done_s;
      frame_abort_r <= abort_s;
    end
  end

  assign p_data      = p_data_r;
  assign data_valid  = data_valid_r;
  assign frame_abort = frame_abort_r;

endmodule

// File: tb/tb_deser_shift_unit.sv
module tb_deser_shift_unit;

  localparam int DW = 8;
  localparam int PW = 6;
  localparam int CW = $clog2(DW + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          des_en = 1'b0;
  logic          sampled_bit = 1'b0;
  logic [PW-1:0] edge_cnt = '0;
  logic [PW-1:0] prescale = PW'(8);
  logic [CW-1:0] frame_len = CW'(8);
  logic          lsb_first = 1'b1;
  logic [DW-1:0] p_data;
  logic          data_valid;
  logic          busy;
  logic          frame_abort;

  int n_cmp = 0;
  int n_fail = 0;

  // Reference model state: captured bits of the current frame in arrival order.
  bit            mq[$];
  int            m_len = 0;
  bit            m_order = 1'b0;
  logic [DW-1:0] e_pdata = '0;
  bit            e_valid = 1'b0;
  bit            e_abort = 1'b0;
  bit            e_busy = 1'b0;

  deser_shift_unit #(.DATA_WIDTH(DW), .PRESC_W(PW)) dut (
    .clk         (clk),
    .rst         (rst),
    .des_en      (des_en),
    .sampled_bit (sampled_bit),
    .edge_cnt    (edge_cnt),
    .prescale    (prescale),
    .frame_len   (frame_len),
    .lsb_first   (lsb_first),
    .p_data      (p_data),
    .data_valid  (data_valid),
    .busy        (busy),
    .frame_abort (frame_abort)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, compared=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    mq.delete();
    e_pdata = '0;
    e_valid = 1'b0;
    e_abort = 1'b0;
    e_busy  = 1'b0;
  endfunction

  // Behavioural model: a frame is a list of captured bits; the word is built
  // arithmetically once the list reaches the latched length.
  function automatic void model_step();
    bit cap;
    int w;
    cap = des_en && (int'(prescale) >= 2) && (int'(edge_cnt) == int'(prescale) - 1);
    e_valid = 1'b0;
    e_abort = 1'b0;
    if (!des_en) begin
      if (mq.size() != 0) begin
        mq.delete();
        e_abort = 1'b1;
      end
    end else if (cap) begin
      if (mq.size() == 0) begin
        m_len = int'(frame_len);
        if (m_len < 5) m_len = 5;
        if (m_len > DW) m_len = DW;
        m_order = lsb_first;
      end
      mq.push_back(sampled_bit);
      if (mq.size() == m_len) begin
        w = 0;
        for (int i = 0; i < m_len; i++) begin
          if (m_order) w = w + (int'(mq[i]) << i);
          else         w = w + (int'(mq[i]) << (m_len - 1 - i));
        end
        e_pdata = DW'(w);
        e_valid = 1'b1;
        mq.delete();
      end
    end
    e_busy = (mq.size() != 0);
  endfunction

  task automatic check_outputs();
    check("p_data", 32'(p_data), 32'(e_pdata));
    check("data_valid", 32'(data_valid), 32'(e_valid));
    check("busy", 32'(busy), 32'(e_busy));
    check("frame_abort", 32'(frame_abort), 32'(e_abort));
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst) model_reset();
    else      model_step();
    #1;
    check_outputs();
  endtask

  // Serialise nbits of tx (tx[0] sent first), one bit per prescale cycles.
  task automatic send_frame(input int presc, input int fl, input int lsb,
                            input logic [15:0] tx, input int nbits,
                            input int chg_at, input int chg_len, input int chg_lsb,
                            input bit idle_after,
                            output int caps_to_valid, output int nvalid);
    int caps;
    caps = 0;
    nvalid = 0;
    caps_to_valid = -1;
    prescale  = PW'(presc);
    frame_len = CW'(fl);
    lsb_first = 1'(lsb);
    des_en    = 1'b1;
    for (int b = 0; b < nbits; b++) begin
      if (b == chg_at) begin
        frame_len = CW'(chg_len);
        lsb_first = 1'(chg_lsb);
      end
      for (int e = 0; e < presc; e++) begin
        edge_cnt    = PW'(e);
        sampled_bit = tx[b];
        if (e == presc - 1) caps++;
        tick();
        if (data_valid === 1'b1) begin
          nvalid++;
          if (caps_to_valid < 0) caps_to_valid = caps;
        end
      end
    end
    if (idle_after) begin
      des_en   = 1'b0;
      edge_cnt = '0;
      tick();
      if (data_valid === 1'b1) nvalid++;
    end
  endtask

  typedef struct {
    int            presc;
    int            fl;
    int            lsb;
    logic [15:0]   tx;
    int            nbits;
    logic [DW-1:0] exp_word;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int ctv;
    int nv;
    int ec;

    vecs[0] = '{presc: 8,  fl: 8,  lsb: 1, tx: 16'h00A5, nbits: 8, exp_word: 8'hA5};
    vecs[1] = '{presc: 8,  fl: 8,  lsb: 0, tx: 16'h00A5, nbits: 8, exp_word: 8'hA5};
    vecs[2] = '{presc: 8,  fl: 5,  lsb: 0, tx: 16'h000D, nbits: 5, exp_word: 8'h16};
    vecs[3] = '{presc: 16, fl: 7,  lsb: 1, tx: 16'h0055, nbits: 7, exp_word: 8'h55};
    vecs[4] = '{presc: 8,  fl: 3,  lsb: 0, tx: 16'h0013, nbits: 5, exp_word: 8'h19};
    vecs[5] = '{presc: 8,  fl: 12, lsb: 1, tx: 16'h00C3, nbits: 8, exp_word: 8'hC3};
    vecs[6] = '{presc: 2,  fl: 8,  lsb: 1, tx: 16'h003C, nbits: 8, exp_word: 8'h3C};
    vecs[7] = '{presc: 3,  fl: 6,  lsb: 0, tx: 16'h002B, nbits: 6, exp_word: 8'h35};

    // Reset state
    #2;
    check_outputs();
    tick();
    rst = 1'b1;
    tick();

    // Table-driven frames
    for (int i = 0; i < 8; i++) begin
      send_frame(vecs[i].presc, vecs[i].fl, vecs[i].lsb, vecs[i].tx, vecs[i].nbits,
                 -1, 0, 0, 1'b1, ctv, nv);
      check($sformatf("vec%0d_p_data", i), 32'(p_data), 32'(vecs[i].exp_word));
      check($sformatf("vec%0d_valid_count", i), 32'(nv), 32'd1);
      check($sformatf("vec%0d_caps_to_valid", i), 32'(ctv), 32'(vecs[i].nbits));
    end

    // Abort after 3 caps, des_en falling on the strobe position
    send_frame(8, 8, 1, 16'h00A5, 8, -1, 0, 0, 1'b1, ctv, nv);
    send_frame(8, 8, 1, 16'h00FF, 3, -1, 0, 0, 1'b0, ctv, nv);
    check("partial_no_valid", 32'(nv), 32'd0);
    des_en   = 1'b0;
    edge_cnt = PW'(7);
    tick();
    check("abort_pulse", 32'(frame_abort), 32'd1);
    check("abort_keeps_pdata", 32'(p_data), 32'hA5);
    check("abort_busy", 32'(busy), 32'd0);
    tick();
    check("abort_single_pulse", 32'(frame_abort), 32'd0);
    send_frame(8, 8, 1, 16'h003C, 8, -1, 0, 0, 1'b1, ctv, nv);
    check("after_abort_p_data", 32'(p_data), 32'h3C);

    // Mid-frame length/order change is ignored until the next frame
    send_frame(8, 8, 1, 16'h0096, 8, 2, 5, 0, 1'b1, ctv, nv);
    check("midchg_p_data", 32'(p_data), 32'h96);
    check("midchg_caps", 32'(ctv), 32'd8);
    send_frame(8, 5, 0, 16'h0019, 5, -1, 0, 0, 1'b1, ctv, nv);
    check("next_frame_msb5", 32'(p_data), 32'h13);

    // Back-to-back frames with a fresh latch of length and order
    send_frame(4, 5, 1, 16'h0015, 5, -1, 0, 0, 1'b0, ctv, nv);
    check("b2b_first", 32'(p_data), 32'h15);
    send_frame(4, 6, 0, 16'h002B, 6, -1, 0, 0, 1'b1, ctv, nv);
    check("b2b_second", 32'(p_data), 32'h35);

    // Asynchronous reset in the middle of a frame
    send_frame(8, 8, 1, 16'h005A, 4, -1, 0, 0, 1'b0, ctv, nv);
    for (int e = 0; e < 3; e++) begin
      edge_cnt = PW'(e);
      tick();
    end
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    check("rst_p_data", 32'(p_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valid", 32'(data_valid), 32'd0);
    check("rst_abort", 32'(frame_abort), 32'd0);
    des_en = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    send_frame(8, 8, 1, 16'h00FF, 8, -1, 0, 0, 1'b1, ctv, nv);
    check("post_rst_ff", 32'(p_data), 32'hFF);

    // prescale 1 and 0 never strobe
    prescale = PW'(1);
    edge_cnt = '0;
    des_en   = 1'b1;
    for (int c = 0; c < 20; c++) tick();
    check("presc1_busy", 32'(busy), 32'd0);
    prescale = PW'(0);
    edge_cnt = {PW{1'b1}};
    for (int c = 0; c < 10; c++) tick();
    check("presc0_busy", 32'(busy), 32'd0);
    check("presc0_p_data", 32'(p_data), 32'hFF);
    des_en = 1'b0;
    tick();

    // Randomised traffic against the model
    prescale = PW'(8);
    ec = 0;
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 299) == 0) prescale = PW'($urandom_range(0, 10));
      if ($urandom_range(0, 49) == 0) frame_len = CW'($urandom_range(0, 15));
      if ($urandom_range(0, 49) == 0) lsb_first = 1'($urandom_range(0, 1));
      des_en      = ($urandom_range(0, 399) != 0);
      sampled_bit = 1'($urandom_range(0, 1));
      edge_cnt    = PW'(ec);
      tick();
      if (ec + 1 >= int'(prescale)) ec = 0;
      else                          ec = ec + 1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
